commit_ctrl: RTL and testbench



---
 rtl/commit_ctrl_pkg.sv | 22 ++
 rtl/commit_ctrl_if.sv | 28 ++
 rtl/commit_ctrl.sv | 93 +++++++++
 tb/tb_commit_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/commit_ctrl_pkg.sv
// Shared types and constants for the retirement/commit slice.
// Physical register file geometry, the commit FSM state type and commit helpers.
package params;
  localparam int unsigned PHYSICAL_REG_FILE_LENGTH = 6;
endpackage

package rv32i_types;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    RESTORE = 2'd2
  } commit_state_t;
endpackage

package commit_ctrl_pkg;
  localparam int unsigned FLUSH_CNT_W = 4;

  // x0 is never renamed, so it neither writes the RRF nor frees a register
  function automatic logic need_rf(input logic regwrite, input logic [4:0] rd);
    return regwrite && (rd != 5'd0);
  endfunction
endpackage

// File: rtl/commit_ctrl_if.sv
// ROB-head, RRF and free-list signals seen by the commit controller.
interface commit_ctrl_if #(
  parameter int unsigned PRL = params::PHYSICAL_REG_FILE_LENGTH
);
  logic           rob_valid;
  logic           rob_regwrite;
  logic [4:0]     rob_rd_s;
  logic [PRL-1:0] rob_pd;
  logic           rob_flush;
  logic           rob_ready;
  logic           rrf_we;
  logic [4:0]     rrf_rd_s;
  logic [PRL-1:0] rrf_rd_v;
  logic [PRL-1:0] rrf_old_pd;
  logic           fl_full;
  logic           fl_push;
  logic [PRL-1:0] fl_push_pd;

  modport master (
    input  rob_valid, rob_regwrite, rob_rd_s, rob_pd, rob_flush, rrf_old_pd, fl_full,
    output rob_ready, rrf_we, rrf_rd_s, rrf_rd_v, fl_push, fl_push_pd
  );

  modport slave (
    output rob_valid, rob_regwrite, rob_rd_s, rob_pd, rob_flush, rrf_old_pd, fl_full,
    input  rob_ready, rrf_we, rrf_rd_s, rrf_rd_v, fl_push, fl_push_pd
  );
endinterface

// File: rtl/commit_ctrl.sv
// Retires one ROB head entry per cycle into the RRF and free list, and runs
// the flush/restore recovery sequence after a flushing entry retires.
module commit_ctrl
  import commit_ctrl_pkg::*;
  import rv32i_types::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned PRL          = params::PHYSICAL_REG_FILE_LENGTH
) (
  input  logic              clk,
  input  logic              rst,
  commit_ctrl_if.master     bus,
  output logic              flush_out,
  output logic              rat_restore,
  output logic [31:0]       commit_cnt
);

  commit_state_t          state_r, state_s;
  logic [FLUSH_CNT_W-1:0] cnt_r, cnt_s;
  logic [31:0]            commit_cnt_r;
  logic                   need_rf_s;
  logic                   commit_s;

  assign need_rf_s  = need_rf(bus.rob_regwrite, bus.rob_rd_s);
  assign commit_cnt = commit_cnt_r;

  // Next-state and retirement outputs; the commit path is zero-latency
  always_comb begin
    state_s         = state_r;
    cnt_s           = cnt_r;
    commit_s        = 1'b0;
    bus.rob_ready   = 1'b0;
    bus.rrf_we      = 1'b0;
    bus.rrf_rd_s    = bus.rob_rd_s;
    bus.rrf_rd_v    = bus.rob_pd;
    bus.fl_push     = 1'b0;
    bus.fl_push_pd  = bus.rrf_old_pd;
    flush_out       = 1'b0;
    rat_restore     = 1'b0;
    case (state_r)
      IDLE: begin
        bus.rob_ready = !(need_rf_s && bus.fl_full);
        commit_s      = bus.rob_valid && bus.rob_ready;
        if (commit_s) begin
          bus.rrf_we  = need_rf_s;
          bus.fl_push = need_rf_s;
          if (bus.rob_flush) begin
            state_s = FLUSH;
            cnt_s   = FLUSH_CNT_W'(FLUSH_CYCLES - 32'd1);
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      FLUSH: begin
        flush_out = 1'b1;
        if (cnt_r == {FLUSH_CNT_W{1'b0}}) begin
          state_s = RESTORE;
        end else begin
          cnt_s = cnt_r - FLUSH_CNT_W'(1);
        end
      end
      RESTORE: begin
        rat_restore = 1'b1;
        state_s     = IDLE;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {FLUSH_CNT_W{1'b0}};
      end
    endcase
  end

  // State, flush down-counter and retirement counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= {FLUSH_CNT_W{1'b0}};
      commit_cnt_r <= 32'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (commit_s) begin
        commit_cnt_r <= commit_cnt_r + 32'd1;
      end else begin
        commit_cnt_r <= commit_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_commit_ctrl.sv
// Randomized plus directed bench for commit_ctrl against a cycle-level model
// of retirement, free-list handshake and flush/restore timing.
module tb_commit_ctrl;
  localparam int unsigned PRL = params::PHYSICAL_REG_FILE_LENGTH;
  localparam int unsigned FC  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_out;
  logic        rat_restore;
  logic [31:0] commit_cnt;

  commit_ctrl_if #(.PRL(PRL)) bus ();

  commit_ctrl #(.FLUSH_CYCLES(FC), .PRL(PRL)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .flush_out   (flush_out),
    .rat_restore (rat_restore),
    .commit_cnt  (commit_cnt)
  );

  always #5 clk = ~clk;

  // Environment RRF: combinational read of the current (pre-write) mapping
  logic [PRL-1:0] rrf_mem [32];
  assign bus.rrf_old_pd = rrf_mem[bus.rrf_rd_s];

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: blocked = cycles left in the flush/restore window
  int          blocked = 0;
  logic [31:0] m_cnt   = 32'd0;

  logic           s_ready, s_we, s_push, s_flush, s_restore;
  logic [PRL-1:0] s_rd_v, s_push_pd;
  logic [4:0]     s_rd_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic rw, input logic [4:0] rd,
                      input logic [PRL-1:0] pd, input logic fl, input logic full,
                      input logic r);
    logic need, e_ready, e_commit, e_we, e_flush, e_restore;
    logic [PRL-1:0] e_old;
    @(negedge clk);
    bus.rob_valid    = v;
    bus.rob_regwrite = rw;
    bus.rob_rd_s     = rd;
    bus.rob_pd       = pd;
    bus.rob_flush    = fl;
    bus.fl_full      = full;
    rst              = r;
    #1;
    need  = rw && (rd != 5'd0);
    e_old = rrf_mem[rd];
    if (blocked == 0) begin
      e_ready   = !(need && full);
      e_commit  = v && e_ready;
      e_we      = e_commit && need;
      e_flush   = 1'b0;
      e_restore = 1'b0;
    end else begin
      e_ready   = 1'b0;
      e_commit  = 1'b0;
      e_we      = 1'b0;
      e_flush   = (blocked > 1);
      e_restore = (blocked == 1);
    end
    s_ready   = bus.rob_ready;
    s_we      = bus.rrf_we;
    s_push    = bus.fl_push;
    s_flush   = flush_out;
    s_restore = rat_restore;
    s_rd_v    = bus.rrf_rd_v;
    s_rd_s    = bus.rrf_rd_s;
    s_push_pd = bus.fl_push_pd;
    chk("rob_ready",   32'(s_ready),   32'(e_ready));
    chk("rrf_we",      32'(s_we),      32'(e_we));
    chk("fl_push",     32'(s_push),    32'(e_we));
    chk("flush_out",   32'(s_flush),   32'(e_flush));
    chk("rat_restore", 32'(s_restore), 32'(e_restore));
    chk("commit_cnt",  commit_cnt,     m_cnt);
    if (e_we) begin
      chk("rrf_rd_s",   32'(s_rd_s),    32'(rd));
      chk("rrf_rd_v",   32'(s_rd_v),    32'(pd));
      chk("fl_push_pd", 32'(s_push_pd), 32'(e_old));
    end
    @(posedge clk);
    if (e_we) rrf_mem[rd] = pd;
    if (r) begin
      blocked = 0;
      m_cnt   = 32'd0;
    end else if (blocked > 0) begin
      blocked--;
    end else if (e_commit) begin
      m_cnt++;
      if (fl) blocked = FC + 1;
    end
  endtask

  task automatic idle(input logic r);
    step(1'b0, 1'b0, 5'd0, '0, 1'b0, 1'b0, r);
  endtask

  initial begin
    int nwe;
    for (int i = 0; i < 32; i++) rrf_mem[i] = PRL'(i);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    chk("lit_reset_ready", 32'(s_ready), 32'd1);
    chk("lit_reset_flush", 32'(s_flush), 32'd0);
    #1 chk("lit_reset_cnt", commit_cnt, 32'd0);

    // Writing commit rd=5 pd=40, old mapping 5
    step(1'b1, 1'b1, 5'd5, PRL'(40), 1'b0, 1'b0, 1'b0);
    chk("lit_t1_we", 32'(s_we), 32'd1);
    chk("lit_t1_rdv", 32'(s_rd_v), 32'd40);
    chk("lit_t1_push", 32'(s_push), 32'd1);
    chk("lit_t1_pushpd", 32'(s_push_pd), 32'd5);
    #1 chk("lit_t1_cnt", commit_cnt, 32'd1);

    // x0 write with free list full still retires
    step(1'b1, 1'b1, 5'd0, PRL'(7), 1'b0, 1'b1, 1'b0);
    chk("lit_x0_ready", 32'(s_ready), 32'd1);
    chk("lit_x0_we", 32'(s_we), 32'd0);
    chk("lit_x0_push", 32'(s_push), 32'd0);
    #1 chk("lit_x0_cnt", commit_cnt, 32'd2);

    // Free-list stall for three cycles
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 5'd3, PRL'(21), 1'b0, 1'b1, 1'b0);
      chk("lit_stall_ready", 32'(s_ready), 32'd0);
      chk("lit_stall_we", 32'(s_we), 32'd0);
    end
    step(1'b1, 1'b1, 5'd3, PRL'(21), 1'b0, 1'b0, 1'b0);
    chk("lit_unstall_we", 32'(s_we), 32'd1);
    #1 chk("lit_unstall_cnt", commit_cnt, 32'd3);

    // Flushing commit: flush 2 cycles, restore, then ready
    step(1'b1, 1'b1, 5'd6, PRL'(33), 1'b1, 1'b0, 1'b0);
    chk("lit_fl_we", 32'(s_we), 32'd1);
    step(1'b1, 1'b1, 5'd7, PRL'(9), 1'b0, 1'b0, 1'b0);
    chk("lit_fl_c1", {29'd0, s_flush, s_restore, s_ready}, 32'b100);
    step(1'b1, 1'b1, 5'd7, PRL'(9), 1'b0, 1'b0, 1'b0);
    chk("lit_fl_c2", {29'd0, s_flush, s_restore, s_ready}, 32'b100);
    step(1'b1, 1'b1, 5'd7, PRL'(9), 1'b0, 1'b0, 1'b0);
    chk("lit_fl_c3", {29'd0, s_flush, s_restore, s_ready}, 32'b010);
    idle(1'b0);
    chk("lit_fl_c4", {29'd0, s_flush, s_restore, s_ready}, 32'b001);
    chk("lit_fl_cnt", commit_cnt, 32'd4);

    // Reset during the second flush cycle abandons the restore
    step(1'b1, 1'b0, 5'd0, '0, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    chk("lit_rst_flush_during", 32'(s_flush), 32'd1);
    idle(1'b0);
    chk("lit_rst_after", {29'd0, s_flush, s_restore, s_ready}, 32'b001);
    chk("lit_rst_cnt", commit_cnt, 32'd0);
    idle(1'b0);
    chk("lit_rst_norestore", 32'(s_restore), 32'd0);

    // Ten back-to-back writing commits
    nwe = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 5'(i + 1), PRL'(i + 50), 1'b0, 1'b0, 1'b0);
      if (s_we && s_push) nwe++;
    end
    chk("lit_b2b_writes", 32'(nwe), 32'd10);
    #1 chk("lit_b2b_cnt", commit_cnt, 32'd10);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
           5'($urandom_range(0, 31)), PRL'($urandom),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 199) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
